// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing for the FIFO pop reader and its skid buffer.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } reader_state_t;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SKID_PTR_W = $clog2(SKID_DEPTH);

endpackage

// File: rtl/reader_skid_buffer.sv
// Two-entry first-in first-out buffer absorbing the FIFO pop-to-data latency.
module reader_skid_buffer
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [SKID_CNT_W-1:0] count
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr_q;
  logic [SKID_PTR_W-1:0] rd_ptr_q;
  logic [SKID_CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + SKID_PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + SKID_PTR_W'(1);
      count_q <= count_q + SKID_CNT_W'(wr_en) - SKID_CNT_W'(rd_en);
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    head_data = mem_q[rd_ptr_q];
    count     = count_q;
  end

endmodule

// File: rtl/fifo_pop_reader.sv
// Burst read controller: pops N words from a fifo_buffer and streams them out
// through a skid buffer with valid/ready, last-word marking and a done pulse.
module fifo_pop_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  req_ready,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_val,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  err_unexpected
);

  localparam int unsigned OCC_W = SKID_CNT_W + 1;

  reader_state_t         state_q, state_d;
  logic [LEN_WIDTH-1:0]  pop_left_q, pop_left_d;
  logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
  logic                  inflight_q;
  logic                  done_q, done_d;
  logic                  err_q;

  logic [SKID_CNT_W-1:0] skid_count;
  logic [DATA_WIDTH-1:0] skid_head;
  logic                  skid_wr;
  logic                  req_fire;
  logic                  out_fire;
  logic                  pop;
  logic [OCC_W-1:0]      occupancy;

  reader_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (skid_wr),
    .wr_data  (fifo_data),
    .rd_en    (out_fire),
    .head_data(skid_head),
    .count    (skid_count)
  );

  always_comb begin
    req_ready = (state_q == IDLE) && !reset;
    req_fire  = req_valid && req_ready;
    out_valid = (skid_count != '0);
    out_fire  = out_valid && out_ready;
    out_last  = out_valid && (out_left_q == LEN_WIDTH'(1));
    out_data  = out_valid ? skid_head : '0;
    skid_wr   = fifo_val && inflight_q;

    // Words held plus words in flight must leave room after this cycle's read.
    occupancy = OCC_W'(skid_count) + OCC_W'(inflight_q);
    pop       = (state_q == READ) && (pop_left_q != '0) && !fifo_empty &&
                (occupancy < OCC_W'(SKID_DEPTH) + OCC_W'(out_fire));
    fifo_pop  = pop;

    state_d    = state_q;
    pop_left_d = pop_left_q;
    out_left_d = out_left_q;
    done_d     = 1'b0;

    if (pop)      pop_left_d = pop_left_q - LEN_WIDTH'(1);
    if (out_fire) out_left_d = out_left_q - LEN_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          pop_left_d = req_len;
          out_left_d = req_len;
          if (req_len == '0) done_d  = 1'b1;
          else               state_d = READ;
        end
      end
      READ: begin
        if (pop && (pop_left_q == LEN_WIDTH'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_fire && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    done           = done_q;
    err_unexpected = err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pop_left_q <= '0;
      out_left_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_left_q <= pop_left_d;
      out_left_q <= out_left_d;
      inflight_q <= pop;
      done_q     <= done_d;
      err_q      <= err_q | (fifo_val && !inflight_q);
    end
  end

endmodule

// File: tb/tb_fifo_pop_reader.sv
// Bench for fifo_pop_reader: behavioural fifo_buffer model plus a stream scoreboard.
module tb_fifo_pop_reader;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [LW-1:0] req_len = '0;
  logic          req_ready;
  logic          fifo_empty = 1'b1;
  logic          fifo_pop;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_val = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          done;
  logic          err_unexpected;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int burst_left = 0;
  int done_cnt = 0;
  int last_cnt = 0;
  int pop_cnt = 0;

  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          flush = 1'b0;
  logic          inject_val = 1'b0;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] pop_w;

  fifo_pop_reader #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_len       (req_len),
    .req_ready     (req_ready),
    .fifo_empty    (fifo_empty),
    .fifo_pop      (fifo_pop),
    .fifo_data     (fifo_data),
    .fifo_val      (fifo_val),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .done          (done),
    .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;

  // fifo_buffer model: registered data_out, val one cycle after an accepted pop.
  always @(posedge clock) begin
    if (flush) fifo_q.delete();
    if (fifo_pop && !fifo_empty && fifo_q.size() > 0) begin
      pop_w = fifo_q.pop_front();
      fifo_data <= pop_w;
      fifo_val  <= 1'b1;
      pop_cnt++;
    end else begin
      fifo_val <= inject_val;
    end
    if (push_en) fifo_q.push_back(push_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic monitor();
    logic [DW-1:0] exp_w;
    forever begin
      @(negedge clock);
      if (flush) exp_q.delete();
      if (push_en) exp_q.push_back(push_data);
      if (mon_en) begin
        if (fifo_pop) begin
          checks++;
          if (fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL pop_while_empty: fifo_empty=%b with fifo_pop=1, required 0", fifo_empty);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_data: got %h, required nothing (scoreboard empty)", out_data);
          end else begin
            exp_w = exp_q.pop_front();
            if (out_data !== exp_w) begin
              errors++;
              $display("FAIL stream_data: got %h, required %h", out_data, exp_w);
            end
          end
          checks++;
          if (out_last !== (burst_left == 1)) begin
            errors++;
            $display("FAIL stream_last: got %b, required %b", out_last, (burst_left == 1));
          end
          if (out_last) last_cnt++;
          if (burst_left > 0) burst_left--;
        end
        if (done) done_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Call only at the start of a cycle (right after tick).
  task automatic push(input logic [DW-1:0] w);
    push_en   = 1'b1;
    push_data = w;
    tick();
    push_en   = 1'b0;
  endtask

  task automatic do_req(input int len, output bit ok);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_len   = LW'(len);
    @(negedge clock);
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      @(negedge clock);
      n++;
    end
    ok = (req_ready === 1'b1);
    if (ok) burst_left = len;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      tick();
      n++;
    end
    ok = (done_cnt != d0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({req_ready, fifo_pop, out_valid, out_last, done, err_unexpected} !== 6'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_values: got rr/pop/v/last/done/err=%b data=%h, required 000000 data=0",
               {req_ready, fifo_pop, out_valid, out_last, done, err_unexpected}, out_data);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({req_ready, fifo_pop, out_valid, done, err_unexpected} !== 5'b10000) begin
      errors++;
      $display("FAIL after_reset: got rr/pop/v/done/err=%b, required 10000",
               {req_ready, fifo_pop, out_valid, done, err_unexpected});
    end
    tick();
    out_ready = 1'b1;
    mon_en    = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    logic [3:0] got, want;
    for (int i = 0; i < 4; i++) push(DW'(32'hA0 + i));
    do_req(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_accept: got req_ready=0, required 1"); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      got  = {fifo_pop, out_valid, out_last, done};
      want = {(k <= 4), (k >= 3 && k <= 6), (k == 6), (k == 7)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL basic_timing T+%0d: got pop/v/last/done=%b, required %b", k, got, want);
      end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (out_data !== DW'(32'hA0 + k - 3)) begin
          errors++;
          $display("FAIL basic_data T+%0d: got %h, required %h", k, out_data, 32'hA0 + k - 3);
        end
      end
      tick();
    end
  endtask

  task automatic test_empty_wait();
    bit ok;
    do_req(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL empty_accept: got req_ready=0, required 1"); end
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin push_en = 1'b1; push_data = 32'h11; end
      @(negedge clock);
      checks++;
      if (fifo_pop !== 1'b0) begin
        errors++;
        $display("FAIL empty_no_pop T+%0d: got fifo_pop=%b, required 0", k, fifo_pop);
      end
      tick();
    end
    push_en = 1'b0;
    @(negedge clock);
    checks++;
    if (fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL empty_first_pop: got fifo_pop=%b, required 1 when fifo_empty falls", fifo_pop);
    end
    tick();
    push(32'h12);
    push(32'h13);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL empty_done: got no done, required one"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int p0, l0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'(32'h60 + i));
    p0 = pop_cnt;
    l0 = last_cnt;
    do_req(6, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_accept: got req_ready=0, required 1"); end
    repeat (10) tick();
    @(negedge clock);
    checks++;
    if (pop_cnt - p0 != 2 || fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got pops=%0d fifo_pop=%b, required pops=2 fifo_pop=0", pop_cnt - p0, fifo_pop);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: got fifo_pop=%b, required 1", fifo_pop);
    end
    wait_done(ok);
    checks++;
    if (!ok || pop_cnt - p0 != 6 || last_cnt - l0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_complete: got done=%b pops=%0d lasts=%0d left=%0d, required 1 6 1 0",
               ok, pop_cnt - p0, last_cnt - l0, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    int p0, d0;
    p0 = pop_cnt;
    d0 = done_cnt;
    do_req(0, ok);
    @(negedge clock);
    checks++;
    if ({done, out_valid, fifo_pop} !== 3'b100 || !ok) begin
      errors++;
      $display("FAIL zero_len: got done/v/pop=%b accepted=%b, required 100 accepted=1",
               {done, out_valid, fifo_pop}, ok);
    end
    repeat (4) tick();
    checks++;
    if (pop_cnt != p0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL zero_len_count: got pops=%0d dones=%0d, required 0 1", pop_cnt - p0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(32'hC0 + i));
    do_req(4, ok);
    repeat (4) tick();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || !ok) begin
      errors++;
      $display("FAIL mid_prefill: got out_valid=%b accepted=%b, required 1 1", out_valid, ok);
    end
    tick();
    mon_en = 1'b0;
    reset  = 1'b1;
    flush  = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clock);
    checks++;
    if ({req_ready, fifo_pop, out_valid, out_last, done, err_unexpected} !== 6'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: got rr/pop/v/last/done/err=%b data=%h, required 000000 data=0",
               {req_ready, fifo_pop, out_valid, out_last, done, err_unexpected}, out_data);
    end
    reset      = 1'b0;
    inject_val = 1'b1;
    tick();
    inject_val = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (err_unexpected !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL unexpected_val: got err=%b out_valid=%b, required 1 0", err_unexpected, out_valid);
    end
    tick();
    burst_left = 0;
    mon_en     = 1'b1;
    out_ready  = 1'b1;
    push(32'hD0);
    push(32'hD1);
    do_req(2, ok);
    wait_done(ok);
    checks++;
    if (!ok || exp_q.size() != 0 || err_unexpected !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_burst: got done=%b left=%0d err=%b, required 1 0 1",
               ok, exp_q.size(), err_unexpected);
    end
  endtask

  task automatic test_random();
    int len, to_push, d0, l0, n, nonzero, dstart, lstart;
    bit pending;
    nonzero = 0;
    dstart  = done_cnt;
    lstart  = last_cnt;
    for (int b = 0; b < 200; b++) begin
      len     = $urandom_range(0, 7);
      to_push = len;
      pending = 1'b1;
      d0      = done_cnt;
      l0      = last_cnt;
      n       = 0;
      if (len != 0) nonzero++;
      while (done_cnt == d0 && n < 200) begin
        req_valid = pending;
        req_len   = LW'(len);
        out_ready = 1'($urandom_range(0, 1));
        push_en   = (to_push > 0) && ($urandom_range(0, 1) == 1);
        if (push_en) begin
          push_data = $urandom;
          to_push--;
        end
        @(negedge clock);
        if (pending && req_ready) begin
          pending    = 1'b0;
          burst_left = len;
        end
        tick();
        n++;
      end
      req_valid = 1'b0;
      push_en   = 1'b0;
      checks++;
      if (done_cnt != d0 + 1 || last_cnt - l0 != ((len != 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL random_burst %0d len=%0d: got dones=%0d lasts=%0d, required 1 %0d",
                 b, len, done_cnt - d0, last_cnt - l0, (len != 0) ? 1 : 0);
      end
    end
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || done_cnt - dstart != 200 || last_cnt - lstart != nonzero) begin
      errors++;
      $display("FAIL random_totals: got left=%0d dones=%0d lasts=%0d, required 0 200 %0d",
               exp_q.size(), done_cnt - dstart, last_cnt - lstart, nonzero);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_empty_wait();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
